// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: prefetches words from a FIFO read port into a small
// circular buffer and presents them as a valid/ready stream.

package FIFO_param_pkg;
    parameter int unsigned WIDTH = 8;
endpackage

module fifo_rd_stream #(
    parameter int unsigned WIDTH     = FIFO_param_pkg::WIDTH,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_rd_err,
    output logic             fifo_rd_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [ERR_W-1:0] rd_err_cnt
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OW = PW + 1;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             inflight_q;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] buf_q [BUF_DEPTH];

    logic             push;
    logic             pop;
    logic             err_inc;
    logic [OW:0]      credit_used;

    // Credit counts the word already requested but not yet returned.
    assign credit_used = {1'b0, occ_q} + {{OW{1'b0}}, inflight_q};
    assign fifo_rd_en  = nRST && !fifo_empty && !flush
                         && (credit_used < (OW + 1)'(BUF_DEPTH));

    assign out_valid  = (occ_q != '0);
    assign out_data   = buf_q[head_q];
    assign rd_err_cnt = err_cnt_q;

    assign push    = inflight_q && !fifo_rd_err && !flush;
    assign pop     = out_valid && out_ready;
    // Errored returns in a flush cycle are swallowed along with the data.
    assign err_inc = fifo_rd_err && !(inflight_q && flush);

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        err_cnt_d = err_cnt_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            occ_d = occ_q + OW'(push) - OW'(pop);
        end
        if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            buf_q[tail_q] <= fifo_rd_data;
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (!nRST)
        !(push && (occ_q == OW'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read-port model
// and a scoreboard for the random-backpressure run.

module tb_fifo_rd_stream;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_rd_data = '0;
    logic         fifo_rd_err = 1'b0;
    logic         fifo_rd_en;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic         flush = 1'b0;
    logic [7:0]   rd_err_cnt;

    logic         e2_empty = 1'b1;
    logic [W-1:0] e2_data = '0;
    logic         e2_err = 1'b0;
    logic         e2_rd_en;
    logic         e2_valid;
    logic [W-1:0] e2_out;
    logic         e2_ready = 1'b0;
    logic         e2_flush = 1'b0;
    logic [1:0]   e2_cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] fq[$];
    bit           eq[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_q[$];
    bit           sb_on = 1'b0;

    always #5 CLK = ~CLK;

    fifo_rd_stream #(.WIDTH(W), .BUF_DEPTH(4), .ERR_W(8)) dut (
        .CLK(CLK), .nRST(nRST), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_err(fifo_rd_err), .fifo_rd_en(fifo_rd_en), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .flush(flush), .rd_err_cnt(rd_err_cnt)
    );

    fifo_rd_stream #(.WIDTH(W), .BUF_DEPTH(4), .ERR_W(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .fifo_empty(e2_empty), .fifo_rd_data(e2_data),
        .fifo_rd_err(e2_err), .fifo_rd_en(e2_rd_en), .out_valid(e2_valid),
        .out_data(e2_out), .out_ready(e2_ready), .flush(e2_flush), .rd_err_cnt(e2_cnt)
    );

    // FIFO read port: data and error flag appear the cycle after an accepted read.
    always @(posedge CLK) begin
        if (fifo_rd_en && (fq.size() != 0)) begin
            fifo_rd_data <= fq.pop_front();
            fifo_rd_err  <= eq.pop_front();
        end else begin
            fifo_rd_err <= 1'b0;
        end
    end

    // Empty flag moves on the falling edge so it never races the read edge.
    always @(negedge CLK) fifo_empty = (fq.size() == 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v, input bit e);
        fq.push_back(v);
        eq.push_back(e);
    endtask

    task automatic drain(input string tag, input int maxcyc);
        int n;
        logic [W-1:0] e;
        n = 0;
        while ((exp_q.size() != 0) && (n < maxcyc)) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk(tag, 32'(out_data), 32'(e));
            end
            step();
            n++;
        end
        chk({tag, "_remaining"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    always @(posedge CLK) begin
        logic [W-1:0] e;
        if (sb_on) begin
            chk("occ_bound", 32'(dut.occ_q <= 4), 32'd1);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_extra_beat", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_order", 32'(out_data), 32'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_err_cnt", 32'(rd_err_cnt), 32'd0);
        chk("rst_e2_cnt", 32'(e2_cnt), 32'd0);
        step();
        nRST = 1'b1;
        step();

        // Streaming 0x10..0x1F with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) load(W'(8'h10 + i), 1'b0);
        @(negedge CLK);
        #1;
        chk("stream_issue", 32'(fifo_rd_en), 32'd1);
        chk("stream_v0", 32'(out_valid), 32'd0);
        step();
        chk("stream_v1", 32'(out_valid), 32'd0);
        step();
        for (int i = 0; i < 16; i++) begin
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data", 32'(out_data), 32'h10 + 32'(i));
            step();
        end
        chk("stream_end_valid", 32'(out_valid), 32'd0);
        chk("stream_end_rd_en", 32'(fifo_rd_en), 32'd0);

        // Backpressure: 10 words, consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) load(W'(8'hB0 + i), 1'b0);
        @(negedge CLK);
        #1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (fifo_rd_en) cnt++;
            step();
        end
        chk("bp_reads", 32'(cnt), 32'd4);
        chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_data", 32'(out_data), 32'hB0);
        step();
        step();
        chk("bp_data_held", 32'(out_data), 32'hB0);
        for (int i = 0; i < 10; i++) exp_q.push_back(W'(8'hB0 + i));
        out_ready = 1'b1;
        drain("bp_order", 60);
        chk("bp_after_valid", 32'(out_valid), 32'd0);

        // Read error on the third return
        for (int i = 0; i < 5; i++) load(W'(8'hA0 + i), (i == 2));
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'hA4);
        drain("err_order", 40);
        step();
        chk("err_after_valid", 32'(out_valid), 32'd0);
        chk("err_cnt", 32'(rd_err_cnt), 32'd1);

        // Error counter saturation on a 2-bit counter
        e2_err = 1'b1;
        step();
        step();
        e2_err = 1'b0;
        chk("sat_cnt2", 32'(e2_cnt), 32'd2);
        e2_err = 1'b1;
        step();
        step();
        step();
        e2_err = 1'b0;
        chk("sat_cnt5", 32'(e2_cnt), 32'd3);
        chk("sat_no_issue", 32'(e2_rd_en), 32'd0);
        chk("sat_no_valid", 32'(e2_valid), 32'd0);

        // Flush with three buffered words and one in flight
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) load(W'(8'hC0 + i), 1'b0);
        @(negedge CLK);
        #1;
        step();
        step();
        step();
        step();
        chk("fl_pre_occ", 32'(dut.occ_q), 32'd3);
        chk("fl_pre_inflight", 32'(dut.inflight_q), 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_rd_en", 32'(fifo_rd_en), 32'd0);
        step();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_occ", 32'(dut.occ_q), 32'd0);
        for (int i = 4; i < 8; i++) exp_q.push_back(W'(8'hC0 + i));
        out_ready = 1'b1;
        drain("fl_resume", 40);
        chk("fl_err_cnt_kept", 32'(rd_err_cnt), 32'd1);

        // Random backpressure over 1000 words
        for (int i = 0; i < 1000; i++) begin
            load(W'(i) ^ 8'h3C, 1'b0);
            sb_q.push_back(W'(i) ^ 8'h3C);
        end
        sb_on = 1'b1;
        cnt = 0;
        while ((sb_q.size() != 0) && (cnt < 8000)) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            cnt++;
        end
        sb_on = 1'b0;
        chk("rand_remaining", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("rand_end_valid", 32'(out_valid), 32'd0);

        // Reset mid-stream with two words buffered
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) load(W'(8'hD0 + i), 1'b0);
        @(negedge CLK);
        #1;
        step();
        step();
        step();
        chk("rs_pre_occ", 32'(dut.occ_q), 32'd2);
        #2;
        nRST = 1'b0;
        #1;
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rs_err_cnt", 32'(rd_err_cnt), 32'd0);
        step();
        step();
        nRST = 1'b1;
        #1;
        chk("rs_issue", 32'(fifo_rd_en), 32'd1);
        chk("rs_v0", 32'(out_valid), 32'd0);
        step();
        chk("rs_v1", 32'(out_valid), 32'd0);
        step();
        chk("rs_v2", 32'(out_valid), 32'd1);
        chk("rs_first", 32'(out_data), 32'hD3);
        exp_q.push_back(8'hD3);
        exp_q.push_back(8'hD4);
        exp_q.push_back(8'hD5);
        out_ready = 1'b1;
        drain("rs_order", 30);
        step();
        chk("rs_end_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
